// File: rtl/gol_view_mapper_if.sv
// Pixel-stream, configuration, palette-host and display-bank signals of the view mapper.
// The slave modport is the mapper; the master modport is whoever drives timing/config and serves the bank.
interface gol_view_mapper_if #(
   parameter int GRID_X_BITS  = 8,
   parameter int GRID_Y_BITS  = 8,
   parameter int SPECIES_BITS = 5,
   parameter int COORD_W      = 12
);
   logic [COORD_W-1:0]                 pixel_x;
   logic [COORD_W-1:0]                 pixel_y;
   logic                               de;
   logic                               frame_start;
   logic [1:0]                         cfg_zoom;
   logic [GRID_X_BITS-1:0]             cfg_pan_x;
   logic [GRID_Y_BITS-1:0]             cfg_pan_y;
   logic                               cfg_grid_lines;
   logic                               cfg_cursor_en;
   logic [GRID_X_BITS-1:0]             cfg_cursor_x;
   logic [GRID_Y_BITS-1:0]             cfg_cursor_y;
   logic                               pal_we;
   logic [SPECIES_BITS-1:0]            pal_addr;
   logic [23:0]                        pal_wdata;
   logic [GRID_Y_BITS+GRID_X_BITS-1:0] addr;
   logic [SPECIES_BITS-1:0]            dout;
   logic [7:0]                         r;
   logic [7:0]                         g;
   logic [7:0]                         b;
   logic                               de_out;
   logic                               pal_init_busy;

   modport master (
      output pixel_x, pixel_y, de, frame_start,
      output cfg_zoom, cfg_pan_x, cfg_pan_y, cfg_grid_lines,
      output cfg_cursor_en, cfg_cursor_x, cfg_cursor_y,
      output pal_we, pal_addr, pal_wdata, dout,
      input  addr, r, g, b, de_out, pal_init_busy
   );

   modport slave (
      input  pixel_x, pixel_y, de, frame_start,
      input  cfg_zoom, cfg_pan_x, cfg_pan_y, cfg_grid_lines,
      input  cfg_cursor_en, cfg_cursor_x, cfg_cursor_y,
      input  pal_we, pal_addr, pal_wdata, dout,
      output addr, r, g, b, de_out, pal_init_busy
   );
endinterface

// File: rtl/gol_view_mapper.sv
// Maps active-video pixels onto a toroidal Life grid, fetches species codes and colours them
// through a palette RAM with grid-line and cursor overlays; fixed 3-cycle pixel latency.
module gol_view_mapper #(
   parameter int GRID_X_BITS  = 8,
   parameter int GRID_Y_BITS  = 8,
   parameter int SPECIES_BITS = 5,
   parameter int H_ACTIVE     = 1280,
   parameter int V_ACTIVE     = 720,
   parameter int COORD_W      = 12
) (
   input logic clk,
   input logic rst,
   gol_view_mapper_if.slave bus
);
   localparam logic [23:0] BORDER_RGB = 24'h08081C;
   localparam logic [23:0] GRID_RGB   = 24'h202040;
   localparam logic [23:0] BG_RGB     = 24'h0C0C18;

   typedef enum logic {S_INIT, S_RUN} state_t;

   // Viewport extent in pixels: min(grid cells, active>>zoom) cells, scaled back up by the cell size.
   function automatic logic [COORD_W-1:0] view_px(input int active, input int gbits,
                                                  input logic [1:0] z);
      int cells;
      cells = active >> z;
      if (cells > (1 << gbits)) cells = 1 << gbits;
      return COORD_W'(cells << z);
   endfunction

   function automatic logic [COORD_W-1:0] off_px(input int active, input logic [COORD_W-1:0] span);
      return COORD_W'((active - int'(span)) / 2);
   endfunction

   function automatic logic [23:0] def_entry(input logic [SPECIES_BITS-1:0] i);
      logic [7:0] red;
      if (i == '0) return BG_RGB;
      red = 8'(32'(i) << (8 - SPECIES_BITS));
      return {red, ~red, 8'hFF};
   endfunction

   logic [1:0]             zoom_q;
   logic [GRID_X_BITS-1:0] pan_x_q, cur_x_q;
   logic [GRID_Y_BITS-1:0] pan_y_q, cur_y_q;
   logic                   grid_q, cur_en_q;
   logic [COORD_W-1:0]     view_w_q, view_h_q, off_x_q, off_y_q;
   logic [COORD_W-1:0]     view_w_d, view_h_d;

   always_comb begin
      view_w_d = view_px(H_ACTIVE, GRID_X_BITS, bus.cfg_zoom);
      view_h_d = view_px(V_ACTIVE, GRID_Y_BITS, bus.cfg_zoom);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         zoom_q   <= 2'd2;
         pan_x_q  <= '0;
         pan_y_q  <= '0;
         grid_q   <= 1'b0;
         cur_en_q <= 1'b0;
         cur_x_q  <= '0;
         cur_y_q  <= '0;
         view_w_q <= view_px(H_ACTIVE, GRID_X_BITS, 2'd2);
         view_h_q <= view_px(V_ACTIVE, GRID_Y_BITS, 2'd2);
         off_x_q  <= off_px(H_ACTIVE, view_px(H_ACTIVE, GRID_X_BITS, 2'd2));
         off_y_q  <= off_px(V_ACTIVE, view_px(V_ACTIVE, GRID_Y_BITS, 2'd2));
      end else if (bus.frame_start) begin
         zoom_q   <= bus.cfg_zoom;
         pan_x_q  <= bus.cfg_pan_x;
         pan_y_q  <= bus.cfg_pan_y;
         grid_q   <= bus.cfg_grid_lines;
         cur_en_q <= bus.cfg_cursor_en;
         cur_x_q  <= bus.cfg_cursor_x;
         cur_y_q  <= bus.cfg_cursor_y;
         view_w_q <= view_w_d;
         view_h_q <= view_h_d;
         off_x_q  <= off_px(H_ACTIVE, view_w_d);
         off_y_q  <= off_px(V_ACTIVE, view_h_d);
      end
   end

   // Palette init FSM: one default entry per cycle, host port only live in RUN.
   state_t                  state_q, state_d;
   logic [SPECIES_BITS-1:0] cnt_q, cnt_d;
   logic                    pal_wr_en;
   logic [SPECIES_BITS-1:0] pal_wr_addr;
   logic [23:0]             pal_wr_data;
   logic [23:0]             pal_mem [2**SPECIES_BITS];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pal_wr_en   = 1'b0;
      pal_wr_addr = bus.pal_addr;
      pal_wr_data = bus.pal_wdata;
      case (state_q)
         S_INIT: begin
            pal_wr_en   = 1'b1;
            pal_wr_addr = cnt_q;
            pal_wr_data = def_entry(cnt_q);
            cnt_d       = cnt_q + 1'b1;
            if (cnt_q == '1) state_d = S_RUN;
         end
         default: pal_wr_en = bus.pal_we;
      endcase
   end

   always_ff @(posedge clk) begin
      if (pal_wr_en) pal_mem[pal_wr_addr] <= pal_wr_data;
   end

   assign bus.pal_init_busy = (state_q == S_INIT);

   // Stage 0: unsigned offset subtraction makes pixels left of/above the viewport wrap huge and fail.
   logic [COORD_W-1:0]     dx, dy;
   logic [GRID_X_BITS-1:0] cell_x;
   logic [GRID_Y_BITS-1:0] cell_y;
   logic [3:0]             zmask;
   logic                   in_view, cur_hit, grid_hit;

   always_comb begin
      dx       = bus.pixel_x - off_x_q;
      dy       = bus.pixel_y - off_y_q;
      in_view  = bus.de && (dx < view_w_q) && (dy < view_h_q);
      cell_x   = GRID_X_BITS'(dx >> zoom_q) + pan_x_q;
      cell_y   = GRID_Y_BITS'(dy >> zoom_q) + pan_y_q;
      zmask    = (4'd1 << zoom_q) - 4'd1;
      grid_hit = grid_q && (zoom_q >= 2'd2) &&
                 (((dx[3:0] & zmask) == 4'd0) || ((dy[3:0] & zmask) == 4'd0));
      cur_hit  = cur_en_q && (cell_x == cur_x_q) && (cell_y == cur_y_q);
   end

   // Stage 1: bank address out, overlay flags ride along.
   logic [GRID_Y_BITS+GRID_X_BITS-1:0] addr_q;
   logic de_p1_q, inview_p1_q, cur_p1_q, grid_p1_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q      <= '0;
         de_p1_q     <= 1'b0;
         inview_p1_q <= 1'b0;
         cur_p1_q    <= 1'b0;
         grid_p1_q   <= 1'b0;
      end else begin
         addr_q      <= in_view ? {cell_y, cell_x} : '0;
         de_p1_q     <= bus.de;
         inview_p1_q <= in_view;
         cur_p1_q    <= cur_hit;
         grid_p1_q   <= grid_hit;
      end
   end

   assign bus.addr = addr_q;

   // Stage 2: dout valid, palette read asynchronously, colour chosen.
   logic de_p2_q, inview_p2_q, cur_p2_q, grid_p2_q;
   logic [23:0] pal_rd, rgb_d, rgb_q;
   logic        de_out_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         de_p2_q     <= 1'b0;
         inview_p2_q <= 1'b0;
         cur_p2_q    <= 1'b0;
         grid_p2_q   <= 1'b0;
      end else begin
         de_p2_q     <= de_p1_q;
         inview_p2_q <= inview_p1_q;
         cur_p2_q    <= cur_p1_q;
         grid_p2_q   <= grid_p1_q;
      end
   end

   always_comb begin
      pal_rd = pal_mem[bus.dout];
      rgb_d  = 24'h000000;
      if (!de_p2_q)                              rgb_d = 24'h000000;
      else if (!inview_p2_q || bus.pal_init_busy) rgb_d = BORDER_RGB;
      else if (cur_p2_q)                         rgb_d = pal_rd ^ 24'hFFFFFF;
      else if (grid_p2_q && (bus.dout == '0))    rgb_d = GRID_RGB;
      else                                       rgb_d = pal_rd;
   end

   // Stage 3: registered colour out.
   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_q    <= '0;
         de_out_q <= 1'b0;
      end else begin
         rgb_q    <= rgb_d;
         de_out_q <= de_p2_q;
      end
   end

   assign bus.r      = rgb_q[23:16];
   assign bus.g      = rgb_q[15:8];
   assign bus.b      = rgb_q[7:0];
   assign bus.de_out = de_out_q;
endmodule

// File: tb/tb_gol_view_mapper.sv
// Directed bench for gol_view_mapper: reset/init, mapping at several zooms, palette writes,
// overlays and mid-line reset, with a small display-bank model serving dout.
module tb_gol_view_mapper;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   gol_view_mapper_if #(.GRID_X_BITS(8), .GRID_Y_BITS(8), .SPECIES_BITS(5), .COORD_W(12)) bus ();

   gol_view_mapper #(
      .GRID_X_BITS(8), .GRID_Y_BITS(8), .SPECIES_BITS(5),
      .H_ACTIVE(1280), .V_ACTIVE(720), .COORD_W(12)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [4:0] bank [65536];

   always @(posedge clk) bus.dout <= bank[bus.addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_pix(input string tag, input logic [11:0] x, input logic [11:0] y,
                          input logic d, input logic [15:0] ea, input logic [23:0] ergb);
      bus.pixel_x = x;
      bus.pixel_y = y;
      bus.de      = d;
      @(posedge clk); #1;
      chk({tag, "_addr"}, 32'(bus.addr), 32'(ea));
      bus.de = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk({tag, "_rgb"}, 32'({bus.r, bus.g, bus.b}), 32'(ergb));
   endtask

   task automatic pulse_frame();
      bus.frame_start = 1'b1;
      @(posedge clk); #1;
      bus.frame_start = 1'b0;
   endtask

   task automatic count_init(input string tag, input bit host_poke);
      int n;
      n = 0;
      while (bus.pal_init_busy && n < 100) begin
         if (host_poke && n == 5) begin
            bus.pal_we    = 1'b1;
            bus.pal_addr  = 5'd3;
            bus.pal_wdata = 24'hABCDEF;
         end else begin
            bus.pal_we = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      bus.pal_we = 1'b0;
      chk(tag, 32'(n), 32'd32);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 65536; i++) bank[i] = 5'd0;
      bank[16'h0000] = 5'd1;
      bank[16'h0102] = 5'd3;

      bus.pixel_x = '0;  bus.pixel_y = '0;  bus.de = 1'b0;  bus.frame_start = 1'b0;
      bus.cfg_zoom = 2'd2;  bus.cfg_pan_x = '0;  bus.cfg_pan_y = '0;
      bus.cfg_grid_lines = 1'b0;  bus.cfg_cursor_en = 1'b0;
      bus.cfg_cursor_x = '0;  bus.cfg_cursor_y = '0;
      bus.pal_we = 1'b0;  bus.pal_addr = '0;  bus.pal_wdata = '0;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_addr", 32'(bus.addr), 32'h0);
      chk("rst_rgb", 32'({bus.r, bus.g, bus.b}), 32'h0);
      chk("rst_de_out", 32'(bus.de_out), 32'h0);
      chk("rst_busy", 32'(bus.pal_init_busy), 32'h1);
      count_init("init_len", 1'b1);

      // Latency: nothing after two edges, colour on the third.
      bus.pixel_x = 12'd128;  bus.pixel_y = 12'd0;  bus.de = 1'b1;
      @(posedge clk); #1;
      chk("lat_addr", 32'(bus.addr), 32'h0000);
      bus.de = 1'b0;
      @(posedge clk); #1;
      chk("lat_de_out_early", 32'(bus.de_out), 32'h0);
      @(posedge clk); #1;
      chk("lat_de_out", 32'(bus.de_out), 32'h1);
      chk("lat_rgb", 32'({bus.r, bus.g, bus.b}), 32'h08F7FF);

      run_pix("z2_corner", 12'd1151, 12'd719, 1'b1, 16'hB3FF, 24'h0C0C18);
      run_pix("z2_border", 12'd127, 12'd5, 1'b1, 16'h0000, 24'h08081C);
      run_pix("blank", 12'd200, 12'd200, 1'b0, 16'h0000, 24'h000000);
      run_pix("pal3_default", 12'd136, 12'd4, 1'b1, 16'h0102, 24'h18E7FF);

      bus.pal_we = 1'b1;  bus.pal_addr = 5'd3;  bus.pal_wdata = 24'h123456;
      @(posedge clk); #1;
      bus.pal_we = 1'b0;
      run_pix("pal3_host", 12'd136, 12'd4, 1'b1, 16'h0102, 24'h123456);

      bus.cfg_zoom = 2'd0;
      run_pix("z0_unshadowed", 12'd512, 12'd232, 1'b1, 16'h3A60, 24'h0C0C18);
      pulse_frame();
      run_pix("z0_origin", 12'd512, 12'd232, 1'b1, 16'h0000, 24'h08F7FF);
      run_pix("z0_left_border", 12'd511, 12'd232, 1'b1, 16'h0000, 24'h08081C);

      // frame_start coincident with an active pixel: that pixel still sees zoom 0.
      bus.cfg_zoom = 2'd3;  bus.cfg_pan_x = 8'd200;
      bus.pixel_x = 12'd480;  bus.pixel_y = 12'd0;  bus.de = 1'b1;  bus.frame_start = 1'b1;
      @(posedge clk); #1;
      chk("fs_same_cycle_addr", 32'(bus.addr), 32'h0000);
      bus.frame_start = 1'b0;
      @(posedge clk); #1;
      chk("z3_pan_wrap_addr", 32'(bus.addr), 32'h0004);
      bus.de = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      run_pix("z3_far_corner", 12'd1279, 12'd719, 1'b1, 16'h5967, 24'h0C0C18);

      bus.cfg_zoom = 2'd2;  bus.cfg_pan_x = '0;
      bus.cfg_cursor_en = 1'b1;  bus.cfg_cursor_x = 8'd10;  bus.cfg_cursor_y = 8'd20;
      pulse_frame();
      for (int yy = 80; yy < 84; yy++)
         for (int xx = 168; xx < 172; xx++)
            run_pix("cursor", 12'(xx), 12'(yy), 1'b1, 16'h140A, 24'hF3F3E7);

      bus.cfg_cursor_en = 1'b0;  bus.cfg_grid_lines = 1'b1;
      pulse_frame();
      run_pix("grid_lx0", 12'd148, 12'd21, 1'b1, 16'h0505, 24'h202040);
      run_pix("grid_ly0", 12'd149, 12'd20, 1'b1, 16'h0505, 24'h202040);
      run_pix("grid_inner", 12'd149, 12'd21, 1'b1, 16'h0505, 24'h0C0C18);
      run_pix("grid_live1", 12'd128, 12'd0, 1'b1, 16'h0000, 24'h08F7FF);
      run_pix("grid_live3", 12'd136, 12'd4, 1'b1, 16'h0102, 24'h123456);

      // Reset in the middle of an active run of pixels.
      bus.pixel_x = 12'd136;  bus.pixel_y = 12'd4;  bus.de = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_addr", 32'(bus.addr), 32'h0);
      chk("mid_rst_rgb", 32'({bus.r, bus.g, bus.b}), 32'h0);
      chk("mid_rst_de_out", 32'(bus.de_out), 32'h0);
      chk("mid_rst_busy", 32'(bus.pal_init_busy), 32'h1);
      rst = 1'b0;  bus.de = 1'b0;
      count_init("reinit_len", 1'b0);
      run_pix("reinit_pal3", 12'd136, 12'd4, 1'b1, 16'h0102, 24'h18E7FF);
      run_pix("reinit_grid_off", 12'd148, 12'd21, 1'b1, 16'h0505, 24'h0C0C18);
      run_pix("reinit_zoom2", 12'd512, 12'd232, 1'b1, 16'h3A60, 24'h0C0C18);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/gol_view_mapper.md
# gol_view_mapper

Parametrised viewport and colour stage between the video timing generator and the TMDS encoder. It maps active-video pixel coordinates onto a toroidal Game of Life grid, using a runtime-selectable cell size (1/2/4/8 px) and a pan offset. It reads species codes from the display bank and colours them through a host-writable palette RAM, with optional grid lines and a cursor highlight. All configuration is shadowed so that it changes only at frame boundaries.

## Interface
- GRID_X_BITS, 8, log2 grid width in cells
- GRID_Y_BITS, 8, log2 grid height in cells
- SPECIES_BITS, 5, width of display-bank cell code; palette depth 2^SPECIES_BITS
- H_ACTIVE, 1280, active pixels per line
- V_ACTIVE, 720, active lines per frame
- COORD_W, 12, pixel coordinate width

Ports:
- clk  in  1  pixel clock; single clock domain
- rst  in  1  synchronous, active-high reset
- pixel_x  in  COORD_W  active-area x
- pixel_y  in  COORD_W  active-area y
- de  in  1  data enable
- frame_start  in  1  one-cycle pulse before first active line; shadow load strobe
- cfg_zoom  in  2  cell size = 1<<cfg_zoom px
- cfg_pan_x  in  GRID_X_BITS  cell added to leftmost viewport column
- cfg_pan_y  in  GRID_Y_BITS  cell added to top viewport row
- cfg_grid_lines  in  1  grid-line enable
- cfg_cursor_en  in  1  cursor enable
- cfg_cursor_x  in  GRID_X_BITS  cursor cell x
- cfg_cursor_y  in  GRID_Y_BITS  cursor cell y
- pal_we  in  1  palette write strobe
- pal_addr  in  SPECIES_BITS  palette entry
- pal_wdata  in  24  {R,G,B}
- addr  out  GRID_Y_BITS+GRID_X_BITS  display-bank read address {cell_y, cell_x}
- dout  in  SPECIES_BITS  display-bank data, 1-cycle read latency
- r, g, b  out  8 each  colour
- de_out  out  1  de delayed to match r/g/b
- pal_init_busy  out  1  high while the default palette is loading

## Operation
- **Shadowing.** When frame_start is high, all cfg_* inputs are captured into shadow registers, and these are computed:
  - view_cx = min(2^GRID_X_BITS, H_ACTIVE>>zoom) and view_cy = min(2^GRID_Y_BITS, V_ACTIVE>>zoom)
  - off_x = (H_ACTIVE − (view_cx<<zoom))/2 and off_y likewise
  - cfg_* changes outside frame_start have no effect.
- **Reset state.** zoom=2, pan=0, grid lines off, cursor off, and the derived values for zoom=2 are loaded.
- **Mapping.**
  - in_view = de && pixel_x−off_x < view_cx<<zoom && pixel_y−off_y < view_cy<<zoom, evaluated unsigned so that pixels left of or above the viewport fail.
  - cell_x = (((pixel_x−off_x)>>zoom) + pan_x) mod 2^GRID_X_BITS; cell_y likewise. Both wrap naturally.
  - Local offsets lx = (pixel_x−off_x) & ((1<<zoom)−1), and ly likewise.
  - addr = {cell_y, cell_x} when in_view, else 0.
- **Colour selection**, in priority order:
  - not de: 0x000000
  - de but not in_view, or pal_init_busy: border 0x08081C
  - cursor hit (cfg_cursor_en and cell equals cursor): palette[dout] XOR 0xFFFFFF
  - grid line (cfg_grid_lines, zoom≥2, lx==0 or ly==0, dout==0): 0x202040
  - otherwise: palette[dout]
- **Palette RAM.** 2^SPECIES_BITS×24, single write port plus one read port. A write takes effect the next cycle. A read in the same cycle as a write to the same entry returns the old data.
- **Init FSM.** Two states, INIT and RUN.
  - rst enters INIT with counter=0. Each INIT cycle writes entry i = counter.
    - Entry 0 = 0x0C0C18.
    - Entry i≥1: R = i<<(8−SPECIES_BITS), G = ~R, B = 0xFF.
  - After the last entry the FSM goes to RUN.
  - pal_init_busy = (state==INIT).
  - Host writes during INIT are dropped.
  - rst during RUN, or mid-INIT, restarts INIT from 0 and also reloads the shadow defaults.

## Timing
- **Pipeline**, with inputs at cycle T:
  - T+1: addr is registered, together with in_view, cursor hit, grid-line flag and de.
  - T+2: dout is valid and the palette is read.
  - T+3: r/g/b and de_out are registered.
- Fixed latency is 3 cycles for every pixel, including border and blank pixels.
- **Reset values:** addr=0, r=g=b=0, de_out=0, pal_init_busy=1 in the first cycle after rst is released.
- INIT lasts exactly 2^SPECIES_BITS cycles (32 at defaults).
- A frame_start arriving in the same cycle as an active pixel: that pixel uses the old shadow; the next pixel uses the new one.

## Test plan
- **Reset and init:** assert rst for 1 cycle → pal_init_busy high for 32 cycles. Afterwards, live cell with dout=1 → r,g,b=0x08,0xF7,0xFF; dout=0 → 0x0C0C18.
- **Default mapping (zoom 2):**
  - pixel (128,0) → addr 0x0000
  - (1151,719) → 0xB3FF
  - (127,5) → border 0x08081C
  - r/g/b appear 3 cycles after the pixel input.
- **Zoom 0 and zoom 3 with pan wrap:**
  - zoom 0 → pixel (512,232) gives addr 0x0000.
  - zoom 3, pan_x=200 → pixel (480,0) gives cell_x=4 (260 mod 256).
  - The new zoom only takes effect after the next frame_start.
- **Palette write:**
  - pal_we with entry 3 = 0x123456 → dout=3 produces 0x123456.
  - A write issued during INIT is lost, and entry 3 holds its default.
- **Overlays:**
  - Cursor at (10,20) with dout=0 → 0xF3F3E7 on all 16 pixels of that cell.
  - Grid lines on, dead cell → pixels with lx==0 or ly==0 give 0x202040.
  - Grid lines on, live cell → palette colour is unchanged.
- **Mid-operation reset:** assert rst mid-line → next cycle outputs are 0, and INIT restarts from entry 0.
